// File: rtl/tdm_pkg.sv
// Shared types and default constants for the TDM receive demultiplexer.
package tdm_pkg;

    typedef enum logic [1:0] {
        HUNT,
        ACQUIRE,
        LOCKED
    } tdm_state_t;

    localparam int TDM_NUM_CH      = 4;
    localparam int TDM_LOCK_FRAMES = 2;

endpackage

// File: rtl/tdm_demux_if.sv
// Serial slot link in, parallel frame and status flags out.
interface tdm_demux_if
    import tdm_pkg::*;
#(
    parameter int NUM_CH = TDM_NUM_CH
) ();

    logic              din_valid;
    logic              din;
    logic              frame_sync;
    logic [NUM_CH-1:0] data_out;
    logic              frame_valid;
    logic              locked;
    logic              sync_err;

    // Link side: drives the serial beats, observes the rebuilt frames.
    modport master (
        output din_valid,
        output din,
        output frame_sync,
        input  data_out,
        input  frame_valid,
        input  locked,
        input  sync_err
    );

    // Demultiplexer side.
    modport slave (
        input  din_valid,
        input  din,
        input  frame_sync,
        output data_out,
        output frame_valid,
        output locked,
        output sync_err
    );

endinterface

// File: rtl/tdm_slot_counter.sv
// Modulo-NUM_CH slot position counter.
// Clear wins over load-to-1, which wins over advance; NUM_CH is a power
// of two so the plain binary increment wraps from NUM_CH-1 back to 0.
module tdm_slot_counter #(
    parameter int NUM_CH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear_i,
    input  logic                      load_one_i,
    input  logic                      advance_i,
    output logic [$clog2(NUM_CH)-1:0] slot_o,
    output logic                      last_slot_o
);

    localparam int SW = $clog2(NUM_CH);

    logic [SW-1:0] slot_q;
    logic [SW-1:0] slot_d;

    // Pick the next slot position from the prioritised control inputs.
    always_comb begin
        slot_d = slot_q;
        if (clear_i) begin
            slot_d = '0;
        end else if (load_one_i) begin
            slot_d = SW'(1);
        end else if (advance_i) begin
            slot_d = slot_q + SW'(1);
        end
    end

    // Slot position register.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign slot_o      = slot_q;
    assign last_slot_o = (slot_q == SW'(NUM_CH - 1));

endmodule

// File: rtl/tdm_demux.sv
// TDM receive demultiplexer: tracks slot position, verifies frame-sync
// alignment and publishes rebuilt NUM_CH-bit frames once alignment has
// been seen on LOCK_FRAMES consecutive well-formed frames.
module tdm_demux
    import tdm_pkg::*;
#(
    parameter int NUM_CH      = TDM_NUM_CH,
    parameter int LOCK_FRAMES = TDM_LOCK_FRAMES
) (
    input  logic         clk,
    input  logic         rst,
    tdm_demux_if.slave   bus
);

    localparam int SW = $clog2(NUM_CH);
    localparam int GW = $clog2(LOCK_FRAMES + 1);
    localparam logic [GW-1:0] LOCK_VAL = GW'(LOCK_FRAMES);

    tdm_state_t        state_q;
    tdm_state_t        state_d;

    logic [SW-1:0]     slot;
    logic              last_slot;

    logic [NUM_CH-1:0] shadow_q;
    logic [NUM_CH-1:0] shadow_d;
    logic [GW-1:0]     good_q;
    logic [GW-1:0]     good_d;
    logic [GW-1:0]     good_inc;
    logic [NUM_CH-1:0] data_q;
    logic [NUM_CH-1:0] data_d;
    logic              frame_valid_q;
    logic              sync_err_q;
    logic              locked_q;

    logic              beat;
    logic              at_slot0;
    logic              sync_start;
    logic              early_sync;
    logic              missing_sync;
    logic              in_frame;

    logic              capture0;
    logic              store;
    logic              cnt_clear;
    logic              cnt_load1;
    logic              cnt_advance;
    logic              good_clear;
    logic              good_step;
    logic              publish;
    logic              err;

    // Beat classification against the current slot position.
    assign beat         = bus.din_valid;
    assign at_slot0     = (slot == '0);
    assign sync_start   = beat & bus.frame_sync;
    assign early_sync   = beat & bus.frame_sync & ~at_slot0;
    assign missing_sync = beat & ~bus.frame_sync & at_slot0;
    assign in_frame     = beat & ~early_sync & ~missing_sync;

    // Saturating successor of the good-frame count.
    assign good_inc = (good_q == LOCK_VAL) ? good_q : good_q + GW'(1);

    tdm_slot_counter #(
        .NUM_CH (NUM_CH)
    ) u_slot_counter (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (cnt_clear),
        .load_one_i  (cnt_load1),
        .advance_i   (cnt_advance),
        .slot_o      (slot),
        .last_slot_o (last_slot)
    );

    // Alignment state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    // Alignment state transitions; errors outrank frame completion.
    always_comb begin
        state_d = state_q;
        case (state_q)
            HUNT: begin
                if (sync_start) begin
                    state_d = ACQUIRE;
                end
            end
            ACQUIRE: begin
                if (early_sync) begin
                    state_d = ACQUIRE;
                end else if (missing_sync) begin
                    state_d = HUNT;
                end else if (in_frame && last_slot && (good_inc == LOCK_VAL)) begin
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (early_sync) begin
                    state_d = ACQUIRE;
                end else if (missing_sync) begin
                    state_d = HUNT;
                end
            end
            default: state_d = HUNT;
        endcase
    end

    // Datapath controls decoded from state and beat class.
    always_comb begin
        capture0    = 1'b0;
        store       = 1'b0;
        cnt_clear   = 1'b0;
        cnt_load1   = 1'b0;
        cnt_advance = 1'b0;
        good_clear  = 1'b0;
        good_step   = 1'b0;
        publish     = 1'b0;
        err         = 1'b0;
        case (state_q)
            HUNT: begin
                if (sync_start) begin
                    capture0   = 1'b1;
                    cnt_load1  = 1'b1;
                    good_clear = 1'b1;
                end
            end
            ACQUIRE, LOCKED: begin
                if (early_sync) begin
                    err        = 1'b1;
                    capture0   = 1'b1;
                    cnt_load1  = 1'b1;
                    good_clear = 1'b1;
                end else if (missing_sync) begin
                    err       = 1'b1;
                    cnt_clear = 1'b1;
                end else if (in_frame) begin
                    store       = 1'b1;
                    cnt_advance = 1'b1;
                    if (last_slot) begin
                        if (state_q == ACQUIRE) begin
                            good_step = 1'b1;
                            publish   = (good_inc == LOCK_VAL);
                        end else begin
                            publish = 1'b1;
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    // Next values for shadow, good-frame count and published outputs.
    always_comb begin
        shadow_d = shadow_q;
        if (capture0) begin
            shadow_d[0] = bus.din;
        end
        if (store) begin
            shadow_d[slot] = bus.din;
        end

        good_d = good_q;
        if (good_clear) begin
            good_d = '0;
        end else if (good_step) begin
            good_d = good_inc;
        end

        data_d = data_q;
        if (publish) begin
            data_d = {bus.din, shadow_q[NUM_CH-2:0]};
        end
    end

    // Datapath and output registers; every output leaves from a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q      <= '0;
            good_q        <= '0;
            data_q        <= '0;
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
            locked_q      <= 1'b0;
        end else begin
            shadow_q      <= shadow_d;
            good_q        <= good_d;
            data_q        <= data_d;
            frame_valid_q <= publish;
            sync_err_q    <= err;
            locked_q      <= (state_d == LOCKED);
        end
    end

    assign bus.data_out    = data_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.sync_err    = sync_err_q;
    assign bus.locked      = locked_q;

endmodule

// File: tb/tb_tdm_demux.sv
// Directed bench for tdm_demux with NUM_CH=4, LOCK_FRAMES=2.
// Frames expected to publish are queued when sent and popped when
// frame_valid is seen.
module tb_tdm_demux;
    import tdm_pkg::*;

    localparam int NCH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;
    int fvCount    = 0;
    int errCount   = 0;
    int cycle      = 0;
    int base       = 0;

    logic [NCH-1:0] expQ[$];
    int             fvTimes[$];

    tdm_demux_if #(.NUM_CH(NCH)) bus ();

    tdm_demux #(
        .NUM_CH      (NCH),
        .LOCK_FRAMES (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic d, input logic fs, input logic r);
        @(negedge clk);
        bus.din_valid  = v;
        bus.din        = d;
        bus.frame_sync = fs;
        rst            = r;
    endtask

    task automatic idleCycle();
        @(negedge clk);
        bus.din_valid  = 1'b0;
        bus.din        = 1'b0;
        bus.frame_sync = 1'b0;
        rst            = 1'b0;
        #1;
    endtask

    task automatic sendFrame(input logic [NCH-1:0] val, input bit expectPublish);
        if (expectPublish) expQ.push_back(val);
        for (int k = 0; k < NCH; k++) begin
            applyStimulus(1'b1, val[k], (k == 0), 1'b0);
        end
    endtask

    // Output monitor: counts pulses and checks each published frame.
    always @(negedge clk) begin
        cycle++;
        if (bus.sync_err === 1'b1) errCount++;
        if (bus.frame_valid === 1'b1) begin
            fvCount++;
            fvTimes.push_back(cycle);
            checkOutput("fv_expected", 32'(expQ.size() > 0), 32'd1);
            if (expQ.size() > 0) checkOutput("data_out", 32'(bus.data_out), 32'(expQ.pop_front()));
        end
    end

    initial begin
        bus.din_valid  = 1'b0;
        bus.din        = 1'b0;
        bus.frame_sync = 1'b0;

        // 1. Reset with beats present, then unsynced beats in HUNT.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
        idleCycle();
        checkOutput("rst_data", 32'(bus.data_out), 32'h0);
        checkOutput("rst_fv", 32'(bus.frame_valid), 32'h0);
        checkOutput("rst_locked", 32'(bus.locked), 32'h0);
        checkOutput("rst_err", 32'(bus.sync_err), 32'h0);
        repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        idleCycle();
        checkOutput("hunt_data", 32'(bus.data_out), 32'h0);
        checkOutput("hunt_locked", 32'(bus.locked), 32'h0);
        checkOutput("hunt_fv_count", 32'(fvCount), 32'd0);
        checkOutput("hunt_err_count", 32'(errCount), 32'd0);

        // 2. Acquire lock: first frame silent, second publishes.
        sendFrame(4'b1010, 1'b0);
        idleCycle();
        checkOutput("acq1_fv", 32'(bus.frame_valid), 32'h0);
        checkOutput("acq1_locked", 32'(bus.locked), 32'h0);
        checkOutput("acq1_fv_count", 32'(fvCount), 32'd0);
        sendFrame(4'b0110, 1'b1);
        idleCycle();
        checkOutput("lock_fv", 32'(bus.frame_valid), 32'h1);
        checkOutput("lock_locked", 32'(bus.locked), 32'h1);
        checkOutput("lock_data", 32'(bus.data_out), 32'h6);
        sendFrame(4'b1111, 1'b1);
        idleCycle();
        checkOutput("f3_data", 32'(bus.data_out), 32'hF);
        checkOutput("f3_fv_count", 32'(fvCount), 32'd2);

        // 3. Back-to-back sweep of every 4-bit value.
        base = fvTimes.size();
        for (int v = 0; v < 16; v++) sendFrame(4'(v), 1'b1);
        idleCycle();
        checkOutput("sweep_fv_count", 32'(fvCount), 32'd18);
        checkOutput("sweep_pulses", 32'(fvTimes.size() - base), 32'd16);
        if (fvTimes.size() >= base + 16) begin
            for (int i = 1; i < 16; i++) begin
                checkOutput("sweep_spacing", 32'(fvTimes[base+i] - fvTimes[base+i-1]), 32'd4);
            end
        end

        // 4. Frame 1001 with idle gaps between beats.
        expQ.push_back(4'b1001);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (2) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("gap_no_early_fv", 32'(fvCount), 32'd18);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        idleCycle();
        checkOutput("gap_fv", 32'(bus.frame_valid), 32'h1);
        checkOutput("gap_data", 32'(bus.data_out), 32'h9);
        idleCycle();
        checkOutput("gap_fv_drop", 32'(bus.frame_valid), 32'h0);
        checkOutput("gap_fv_count", 32'(fvCount), 32'd19);

        // 5. Early sync on slot 2 while locked.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        idleCycle();
        checkOutput("early_err", 32'(bus.sync_err), 32'h1);
        checkOutput("early_locked", 32'(bus.locked), 32'h0);
        checkOutput("early_data_hold", 32'(bus.data_out), 32'h9);
        idleCycle();
        checkOutput("early_err_drop", 32'(bus.sync_err), 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        idleCycle();
        checkOutput("reacq1_fv", 32'(bus.frame_valid), 32'h0);
        checkOutput("reacq1_locked", 32'(bus.locked), 32'h0);
        checkOutput("reacq1_fv_count", 32'(fvCount), 32'd19);
        sendFrame(4'b0101, 1'b1);
        idleCycle();
        checkOutput("relock_fv", 32'(bus.frame_valid), 32'h1);
        checkOutput("relock_locked", 32'(bus.locked), 32'h1);
        checkOutput("relock_data", 32'(bus.data_out), 32'h5);

        // 6. Missing sync at slot 0, then reset mid-frame.
        sendFrame(4'b0011, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        idleCycle();
        checkOutput("miss_err", 32'(bus.sync_err), 32'h1);
        checkOutput("miss_locked", 32'(bus.locked), 32'h0);
        checkOutput("miss_data_hold", 32'(bus.data_out), 32'h3);
        checkOutput("miss_fv_count", 32'(fvCount), 32'd21);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        idleCycle();
        checkOutput("miss_hunt_err", 32'(bus.sync_err), 32'h0);
        checkOutput("err_count", 32'(errCount), 32'd2);
        sendFrame(4'b1100, 1'b0);
        sendFrame(4'b0111, 1'b1);
        idleCycle();
        checkOutput("relock2_locked", 32'(bus.locked), 32'h1);
        checkOutput("relock2_data", 32'(bus.data_out), 32'h7);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        idleCycle();
        checkOutput("mid_rst_data", 32'(bus.data_out), 32'h0);
        checkOutput("mid_rst_fv", 32'(bus.frame_valid), 32'h0);
        checkOutput("mid_rst_locked", 32'(bus.locked), 32'h0);
        checkOutput("mid_rst_err", 32'(bus.sync_err), 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (6) idleCycle();
        checkOutput("final_fv_count", 32'(fvCount), 32'd22);
        checkOutput("final_err_count", 32'(errCount), 32'd2);
        checkOutput("final_queue_empty", 32'(expQ.size()), 32'd0);
        checkOutput("final_data", 32'(bus.data_out), 32'h0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
